// File: rtl/keyscan_ctrl_if.sv
// Register-bus port of keyscan_ctrl: word address, 32-bit data, cyc/we strobes.
// The slave acks one cycle after cyc; the master holds cyc until it sees ack.
interface keyscan_ctrl_if;
  logic [2:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/keyscan_ctrl.sv
// Debounced key-matrix scanner feeding a press/release event FIFO popped over the register bus.
// Bus ack 1 cycle after cyc; a full FIFO holds the pending event and sets OVF. Optional irq: KEYSCAN_CTRL_IRQ_EN.
module keyscan_ctrl #(
  parameter int N_COLS         = 12,
  parameter int N_ROWS         = 4,
  parameter int SETTLE_CYCLES  = 256,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_COLS-1:0] km_col,
  output logic [N_ROWS-1:0] km_row,
  keyscan_ctrl_if.slave     wb
`ifdef KEYSCAN_CTRL_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int NK = N_ROWS * N_COLS;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_COMPARE,
    S_NEXT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [SW-1:0]     r_settle;
  logic [N_COLS-1:0] r_sample;
  logic [NK-1:0]     r_deb;
  logic [DW-1:0]     r_cnt [NK];

  logic              r_en;
  logic              r_ovf;
  logic              w_irq_en;

  logic [8:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;

  logic              r_ack;
  logic              r_evt_vld;
  logic [31:0]       r_rdata;
  logic [31:0]       w_rd_map;
  logic [8:0]        w_head;

  logic [KW-1:0]     w_kidx;
  logic              w_samp_bit;
  logic              w_deb_bit;
  logic [DW-1:0]     w_cnt_cur;
  logic [DW-1:0]     w_cnt_inc;
  logic              w_cmp;
  logic              w_diff;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_leave;
  logic              w_unused;

  // ---------------- scan FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (r_en) w_state_nxt = S_DRIVE;
      S_DRIVE:   if (r_settle == SW'(SETTLE_CYCLES - 1)) w_state_nxt = S_SAMPLE;
      S_SAMPLE:  w_state_nxt = S_COMPARE;
      S_COMPARE: if (r_col == CW'(N_COLS - 1)) w_state_nxt = S_NEXT;
      S_NEXT:    w_state_nxt = S_DRIVE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (!r_en) w_state_nxt = S_IDLE;
  end

  assign w_leave = (r_state != S_IDLE) && !r_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_settle <= '0;
      r_sample <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_DRIVE:   r_settle <= (w_state_nxt == S_DRIVE) ? r_settle + 1'b1 : '0;
        S_SAMPLE: begin
          r_sample <= ~km_col;
          r_col    <= '0;
        end
        S_COMPARE: r_col <= r_col + 1'b1;
        S_NEXT:    r_row <= (r_row == RW'(N_ROWS - 1)) ? '0 : r_row + 1'b1;
        default: ;
      endcase
      if (w_state_nxt == S_IDLE) begin
        r_row    <= '0;
        r_settle <= '0;
      end
    end
  end

  // Row stays driven through SAMPLE so the captured columns belong to it.
  assign km_row = (r_state == S_DRIVE || r_state == S_SAMPLE) ?
                  ~(N_ROWS'(1) << r_row) : '1;

  // ---------------- debounce ----------------
  always_comb begin
    w_kidx     = KW'(int'(r_row) * N_COLS + int'(r_col));
    w_samp_bit = r_sample[r_col];
    w_deb_bit  = r_deb[w_kidx];
    w_cnt_cur  = r_cnt[w_kidx];
    w_cnt_inc  = (w_cnt_cur >= DW'(DEBOUNCE_SCANS)) ? DW'(DEBOUNCE_SCANS) : w_cnt_cur + 1'b1;
    w_cmp      = (r_state == S_COMPARE) && r_en;
    w_diff     = w_cmp && (w_samp_bit != w_deb_bit);
    w_push_req = w_diff && (w_cnt_inc == DW'(DEBOUNCE_SCANS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= '0;
      for (int k = 0; k < NK; k++) r_cnt[k] <= '0;
    end else if (w_leave) begin
      for (int k = 0; k < NK; k++) r_cnt[k] <= '0;
    end else if (w_cmp) begin
      if (!w_diff) begin
        r_cnt[w_kidx] <= '0;
      end else if (!w_push_req) begin
        r_cnt[w_kidx] <= w_cnt_inc;
      end else if (w_push) begin
        r_deb[w_kidx] <= ~w_deb_bit;
        r_cnt[w_kidx] <= '0;
      end else begin
        // FIFO full: park at threshold so the next scan of this key retries.
        r_cnt[w_kidx] <= DW'(DEBOUNCE_SCANS);
      end
    end
  end

  // ---------------- event FIFO ----------------
  assign w_wr    = r_ack & wb.wb_cyc & wb.wb_we;
  assign w_pop   = r_ack & wb.wb_cyc & r_evt_vld;
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_samp_bit, 4'(r_row), 4'(r_col)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------- registers / bus ----------------
`ifdef KEYSCAN_CTRL_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
  assign w_unused = ^wb.wb_wdata[31:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && wb.wb_addr == 3'd0) r_irq_en <= wb.wb_wdata[1];
      r_irq <= r_irq_en & (~w_empty | r_ovf);
    end
  end
`else
  assign w_irq_en = 1'b0;
  assign w_unused = ^{wb.wb_wdata[31:3], wb.wb_wdata[1]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && wb.wb_addr == 3'd0) begin
        r_en <= wb.wb_wdata[0];
        if (wb.wb_wdata[2]) r_ovf <= 1'b0;
      end
      if (w_push_req && !w_push) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_rd_map = '0;
    case (wb.wb_addr)
      3'd0: w_rd_map = {16'd0, 8'(r_level), 5'd0, r_ovf, w_irq_en, r_en};
      3'd1: if (!w_empty) w_rd_map = {1'b1, 22'd0, w_head};
      3'd4, 3'd5, 3'd6, 3'd7: begin
        for (int r = 0; r < N_ROWS && r < 4; r++) begin
          if (wb.wb_addr[1:0] == 2'(r)) w_rd_map[N_COLS-1:0] = r_deb[r*N_COLS +: N_COLS];
        end
      end
      default: ;
    endcase
  end

  // Remember whether the returned EVENT word was valid so a push landing
  // between load and ack is never popped unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_evt_vld <= 1'b0;
    end else begin
      r_ack <= wb.wb_cyc & ~r_ack;
      if (wb.wb_cyc & ~r_ack) begin
        r_rdata   <= w_rd_map;
        r_evt_vld <= ~wb.wb_we & (wb.wb_addr == 3'd1) & ~w_empty;
      end else begin
        r_rdata   <= '0;
        r_evt_vld <= 1'b0;
      end
    end
  end

  assign wb.wb_ack   = r_ack;
  assign wb.wb_rdata = r_rdata;

endmodule

// File: tb/tb_keyscan_ctrl.sv
// Scoreboard bench for keyscan_ctrl: bus tasks queue expected read data, a negedge
// monitor pops and compares on every ack; a small matrix model drives km_col.
module tb_keyscan_ctrl;
  localparam int NC = 12;
  localparam int NR = 4;
  localparam int SC = 4;
  localparam int DS = 2;
  localparam int FD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NC-1:0]          km_col;
  logic [NR-1:0]          km_row;
  logic [NR-1:0][NC-1:0]  keys;
`ifdef KEYSCAN_CTRL_IRQ_EN
  logic                   irq;
`endif

  keyscan_ctrl_if wb ();

  keyscan_ctrl #(
    .N_COLS(NC), .N_ROWS(NR), .SETTLE_CYCLES(SC),
    .DEBOUNCE_SCANS(DS), .FIFO_DEPTH(FD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .km_col(km_col),
    .km_row(km_row),
    .wb    (wb)
`ifdef KEYSCAN_CTRL_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  // Closed key pulls its column low while its row is driven low.
  always_comb begin
    km_col = '1;
    for (int r = 0; r < NR; r++) if (!km_row[r]) km_col = km_col & ~keys[r];
  end

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic prev_ack = 1'b0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  bit          rd_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (wb.wb_ack) begin
        checks++;
        if (prev_ack) begin
          errors++;
          $display("FAIL ack_single: ack high on two consecutive cycles");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack with no access outstanding");
        end else begin
          logic [31:0] e;
          string n;
          bit r;
          e = exp_q.pop_front();
          n = name_q.pop_front();
          r = rd_q.pop_front();
          if (r) begin
            checks++;
            if (wb.wb_rdata !== e) begin
              errors++;
              $display("FAIL %s: got %h expected %h", n, wb.wb_rdata, e);
            end
          end
        end
      end else begin
        checks++;
        if (wb.wb_rdata !== 32'h0) begin
          errors++;
          $display("FAIL rdata_idle: got %h expected 00000000", wb.wb_rdata);
        end
      end
    end
    prev_ack = wb.wb_ack;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    rd_q.push_back(1'b1);
    wb.wb_addr = a;
    wb.wb_we   = 1'b0;
    wb.wb_cyc  = 1'b1;
    tick(2);
    wb.wb_cyc  = 1'b0;
    tick(1);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    exp_q.push_back(32'h0);
    name_q.push_back("write");
    rd_q.push_back(1'b0);
    wb.wb_addr  = a;
    wb.wb_wdata = d;
    wb.wb_we    = 1'b1;
    wb.wb_cyc   = 1'b1;
    tick(2);
    wb.wb_cyc   = 1'b0;
    wb.wb_we    = 1'b0;
    tick(1);
  endtask

  task automatic wait_row(input int r, input bit active);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if ((km_row[r] == 1'b0) == active) found = 1'b1;
      else tick(1);
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_row%0d: row never reached state %0d", r, active);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    keys        = '0;
    wb.wb_addr  = '0;
    wb.wb_wdata = '0;
    wb.wb_we    = 1'b0;
    wb.wb_cyc   = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    mon_en = 1'b1;

    chk("rst_km_row", 32'(km_row), 32'hF);
    bus_rd(3'd0, 32'h0, "rst_csr");
    bus_rd(3'd1, 32'h0, "rst_evt");
    bus_rd(3'd6, 32'h0, "rst_row2");

    // Press and release of r2c5
    bus_wr(3'd0, 32'h1);
    keys[2][5] = 1'b1;
    tick(300);
    bus_rd(3'd0, 32'h0000_0101, "csr_lvl1");
    bus_rd(3'd1, 32'h8000_0125, "evt_press");
    bus_rd(3'd0, 32'h0000_0001, "csr_lvl0");
    bus_rd(3'd6, 32'h0000_0020, "row2_state");
    bus_rd(3'd1, 32'h0, "evt_empty");
    keys[2][5] = 1'b0;
    tick(300);
    bus_rd(3'd1, 32'h8000_0025, "evt_release");
    bus_rd(3'd6, 32'h0, "row2_clear");

    // Bounce on r0c0: alternate samples never reach the threshold
    wait_row(0, 1'b0);
    keys[0][0] = 1'b1;
    repeat (6) begin
      wait_row(0, 1'b1);
      wait_row(0, 1'b0);
      keys[0][0] = ~keys[0][0];
    end
    keys[0][0] = 1'b0;
    tick(300);
    bus_rd(3'd0, 32'h0000_0001, "bounce_lvl0");
    bus_rd(3'd4, 32'h0, "bounce_row0");

    // Overflow: three presses into a 2-deep FIFO, aligned to scan start
    wait_row(3, 1'b1);
    wait_row(3, 1'b0);
    keys[0][1]  = 1'b1;
    keys[1][2]  = 1'b1;
    keys[3][11] = 1'b1;
    tick(400);
    bus_rd(3'd0, 32'h0000_0205, "ovf_csr");
    bus_rd(3'd4, 32'h0000_0002, "row0_state");
    bus_rd(3'd5, 32'h0000_0004, "row1_state");
    bus_rd(3'd7, 32'h0, "row3_held");
    bus_rd(3'd1, 32'h8000_0101, "ovf_pop1");
    bus_rd(3'd1, 32'h8000_0112, "ovf_pop2");
    tick(200);
    bus_rd(3'd1, 32'h8000_013B, "ovf_retry");
    bus_rd(3'd7, 32'h0000_0800, "row3_state");
    bus_rd(3'd0, 32'h0000_0005, "ovf_sticky");
    bus_wr(3'd0, 32'h5);
    bus_rd(3'd0, 32'h0000_0001, "ovf_clr");

    // Disable while row1 is being driven; queued release must survive
    keys[0][1] = 1'b0;
    tick(300);
    wait_row(1, 1'b0);
    wait_row(1, 1'b1);
    bus_wr(3'd0, 32'h0);
    chk("dis_km_row", 32'(km_row), 32'hF);
    tick(100);
    chk("dis_idle_row", 32'(km_row), 32'hF);
    bus_rd(3'd0, 32'h0000_0100, "dis_csr");
    bus_rd(3'd1, 32'h8000_0001, "dis_evt");
    bus_rd(3'd5, 32'h0000_0004, "dis_state_kept");

    bus_wr(3'd0, 32'h3);
`ifdef KEYSCAN_CTRL_IRQ_EN
    bus_rd(3'd0, 32'h0000_0003, "csr_irq_en");
    chk("irq_low", 32'(irq), 32'h0);
`else
    bus_rd(3'd0, 32'h0000_0001, "csr_irq_ro");
`endif
    keys[1][0] = 1'b1;
    tick(300);
`ifdef KEYSCAN_CTRL_IRQ_EN
    chk("irq_high", 32'(irq), 32'h1);
`endif
    bus_rd(3'd1, 32'h8000_0110, "irq_evt");
`ifdef KEYSCAN_CTRL_IRQ_EN
    chk("irq_clear", 32'(irq), 32'h0);
`endif

    // Reset in the middle of scanning
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_km_row", 32'(km_row), 32'hF);
    bus_rd(3'd0, 32'h0, "rst2_csr");
    bus_rd(3'd5, 32'h0, "rst2_row1");
    bus_rd(3'd1, 32'h0, "rst2_evt");

    tick(5);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL ack_missing: %0d accesses never acked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
